// File: rtl/io_key_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module   : io_pkg
// Purpose  : Shared types and constants for the I/O key capture block.
//            Holds the per-key debounce state encoding and the I/O address
//            decode bit positions used by the CPU-side address decoder.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package io_pkg;

    // Per-key debounce state, explicit 2-bit encoding.
    typedef enum logic [1:0] {
        KEY_UP     = 2'd0,
        KEY_DEB_DN = 2'd1,
        KEY_DOWN   = 2'd2,
        KEY_DEB_UP = 2'd3
    } key_state_t;

    // I/O address decode bits (one-hot select bits above the I/O base).
    localparam int c_io_leds_bit = 2;
    localparam int c_io_hex_bit  = 3;
    localparam int c_io_key_bit  = 4;
    localparam int c_io_sw_bit   = 5;
    localparam int c_io_base_bit = 8;

endpackage
`default_nettype wire

// File: rtl/io_key_capture_if.sv
`default_nettype none
// ============================================================================
// Module   : io_key_capture_if
// Purpose  : CPU register-access bus for the key capture block.
// Signals  : sel   - access targets this block (decoded address)
//            we    - write strobe, qualified by sel
//            wdata - 32-bit write data
//            rdata - 32-bit read data (zero when not selected)
// Modports : master (CPU side), slave (peripheral side)
// Revision : 1.0 - initial release
// ============================================================================
interface io_key_capture_if;

    logic        sel;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output sel, output we, output wdata, input  rdata);
    modport slave  (input  sel, input  we, input  wdata, output rdata);

endinterface
`default_nettype wire

// File: rtl/io_key_capture_key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce
// Purpose  : One push-button: 2-flop synchronizer, debounce FSM and counter.
// Ports    : clk          - system clock
//            rst          - asynchronous active-high reset
//            i_key_n      - raw active-low button, asynchronous to clk
//            o_level      - registered debounced level, 1 = held down
//            o_enter_down - high in the cycle whose edge moves the FSM to DOWN
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key_n,
    output logic o_level,
    output logic o_enter_down
);

    localparam int                 c_cnt_w   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    logic               r_meta;
    logic               r_sync;
    key_state_t         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_level;

    // The flops carry the inverted key so that their reset value (0) reads
    // as "key up"; a key held through reset then looks like a fresh press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= ~i_key_n;
            r_sync <= r_meta;
        end
    end

    // The counter only ever counts up inside DEB_DN/DEB_UP and leaves those
    // states once it equals DEBOUNCE_CYCLES, so it cannot wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= KEY_UP;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            case (r_state)
                KEY_UP: begin
                    if (r_sync) begin
                        r_state <= KEY_DEB_DN;
                        r_cnt   <= c_cnt_one;
                    end else begin
                        r_cnt   <= '0;
                    end
                end
                KEY_DEB_DN: begin
                    if (!r_sync) begin
                        r_state <= KEY_UP;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_cnt_max) begin
                        r_state <= KEY_DOWN;
                        r_cnt   <= '0;
                        r_level <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt + c_cnt_one;
                    end
                end
                KEY_DOWN: begin
                    if (!r_sync) begin
                        r_state <= KEY_DEB_UP;
                        r_cnt   <= c_cnt_one;
                    end else begin
                        r_cnt   <= '0;
                    end
                end
                KEY_DEB_UP: begin
                    if (r_sync) begin
                        r_state <= KEY_DOWN;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_cnt_max) begin
                        r_state <= KEY_UP;
                        r_cnt   <= '0;
                        r_level <= 1'b0;
                    end else begin
                        r_cnt   <= r_cnt + c_cnt_one;
                    end
                end
                default: begin
                    r_state <= KEY_UP;
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end
            endcase
        end
    end

    assign o_level      = r_level;
    assign o_enter_down = (r_state == KEY_DEB_DN) && r_sync && (r_cnt == c_cnt_max);

endmodule
`default_nettype wire

// File: rtl/io_key_capture.sv
`default_nettype none
// ============================================================================
// Module   : io_key_capture
// Purpose  : Debounced push-button capture with sticky press flags and a
//            CPU register interface.
// Ports    : clk     - system clock (single clock domain)
//            reset   - asynchronous active-high reset
//            key_n   - raw active-low buttons [NKEYS]
//            bus     - CPU access (slave): sel/we/wdata in, rdata out
//                      read  = {24'b0, pressed[3:0], level[3:0]}
//                      write = clear pressed[i] where wdata[4+i]=1
//            level   - debounced key state, 1 = held down [NKEYS]
//            pressed - sticky press-event flags [NKEYS]
// Revision : 1.0 - initial release
// ============================================================================
module io_key_capture
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int NKEYS           = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NKEYS-1:0]   key_n,
    io_key_capture_if.slave    bus,
    output logic [NKEYS-1:0]   level,
    output logic [NKEYS-1:0]   pressed
);

    logic [NKEYS-1:0] w_enter_down;
    logic [NKEYS-1:0] w_clr;
    logic [NKEYS-1:0] r_pressed;
    logic [3:0]       w_level_rd;
    logic [3:0]       w_pressed_rd;
    logic             w_wr;
    logic             w_unused_wdata;

    assign w_wr = bus.sel & bus.we;

    generate
        for (genvar i = 0; i < NKEYS; i++) begin : g_key
            key_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_key_debounce (
                .clk          (clk),
                .rst          (reset),
                .i_key_n      (key_n[i]),
                .o_level      (level[i]),
                .o_enter_down (w_enter_down[i])
            );

            // Keys whose clear bit would fall past wdata[31] are not clearable.
            if (i < 28) begin : g_clr
                assign w_clr[i] = w_wr & bus.wdata[4+i];
            end else begin : g_no_clr
                assign w_clr[i] = 1'b0;
            end
        end

        // Register view always exposes four key slots; absent keys read 0.
        for (genvar j = 0; j < 4; j++) begin : g_rd
            if (j < NKEYS) begin : g_map
                assign w_level_rd[j]   = level[j];
                assign w_pressed_rd[j] = r_pressed[j];
            end else begin : g_pad
                assign w_level_rd[j]   = 1'b0;
                assign w_pressed_rd[j] = 1'b0;
            end
        end
    endgenerate

    // Set term is OR-ed after the clear so a press landing in the same cycle
    // as a clear write is never lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pressed <= '0;
        end else begin
            r_pressed <= (r_pressed & ~w_clr) | w_enter_down;
        end
    end

    assign pressed   = r_pressed;
    assign bus.rdata = bus.sel ? {24'b0, w_pressed_rd, w_level_rd} : 32'b0;

    // Only the clear-mask bits of wdata carry meaning.
    assign w_unused_wdata = ^bus.wdata;

endmodule
`default_nettype wire

// File: tb/tb_io_key_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_key_capture
// Purpose  : Self-checking bench for io_key_capture. A reference model
//            tracks each key as "synchronized sample delayed two cycles;
//            level flips after DEBOUNCE_CYCLES+1 consecutive differing
//            samples", plus sticky press flags with write-1-to-clear.
//            Directed scenarios are followed by a randomized phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_key_capture;

    localparam int c_deb   = 4;
    localparam int c_nkeys = 4;

    logic       clk;
    logic       reset;
    logic [3:0] key_n;
    logic [3:0] level;
    logic [3:0] pressed;

    io_key_capture_if bus ();

    io_key_capture #(
        .DEBOUNCE_CYCLES (c_deb),
        .NKEYS           (c_nkeys)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .key_n   (key_n),
        .bus     (bus),
        .level   (level),
        .pressed (pressed)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state per key.
    bit m_s1      [4];
    bit m_s2      [4];
    bit m_level   [4];
    bit m_pressed [4];
    int m_run     [4];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_s1[k]      = 1'b0;
            m_s2[k]      = 1'b0;
            m_level[k]   = 1'b0;
            m_pressed[k] = 1'b0;
            m_run[k]     = 0;
        end
    endtask

    function automatic logic [3:0] m_level_vec();
        logic [3:0] v;
        for (int k = 0; k < 4; k++) v[k] = m_level[k];
        return v;
    endfunction

    function automatic logic [3:0] m_pressed_vec();
        logic [3:0] v;
        for (int k = 0; k < 4; k++) v[k] = m_pressed[k];
        return v;
    endfunction

    task automatic check_model();
        logic [31:0] exp_rd;
        exp_rd = bus.sel ? {24'b0, m_pressed_vec(), m_level_vec()} : 32'h0;
        chk("level",   32'(level),   32'(m_level_vec()));
        chk("pressed", 32'(pressed), 32'(m_pressed_vec()));
        chk("rdata",   bus.rdata,    exp_rd);
    endtask

    // One clock edge: inputs seen before the edge drive the model update.
    task automatic tick();
        logic [3:0]  kn;
        logic        wr;
        logic [31:0] wd;
        bit          set_ev;
        kn = key_n;
        wr = bus.sel & bus.we;
        wd = bus.wdata;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            for (int k = 0; k < 4; k++) begin
                set_ev = 1'b0;
                if (m_s2[k] != m_level[k]) begin
                    m_run[k]++;
                    if (m_run[k] == c_deb + 1) begin
                        m_level[k] = !m_level[k];
                        m_run[k]   = 0;
                        set_ev     = m_level[k];
                    end
                end else begin
                    m_run[k] = 0;
                end
                m_s2[k] = m_s1[k];
                m_s1[k] = !kn[k];
                if (set_ev)
                    m_pressed[k] = 1'b1;
                else if (wr && wd[4+k])
                    m_pressed[k] = 1'b0;
            end
        end
        #1;
        check_model();
    endtask

    // Called just after a tick: pulse reset mid-cycle, well clear of edges.
    task automatic async_reset_pulse();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("rst_level",   32'(level),   32'h0);
        chk("rst_pressed", 32'(pressed), 32'h0);
        #2;
        reset = 1'b0;
    endtask

    task automatic write_clear(input logic [31:0] wd);
        bus.sel   = 1'b1;
        bus.we    = 1'b1;
        bus.wdata = wd;
        tick();
        bus.we    = 1'b0;
        bus.wdata = 32'h0;
    endtask

    initial begin
        reset     = 1'b1;
        key_n     = 4'hF;
        bus.sel   = 1'b0;
        bus.we    = 1'b0;
        bus.wdata = 32'h0;
        model_reset();
        repeat (3) tick();
        #3;
        reset = 1'b0;

        // Idle after reset.
        bus.sel = 1'b1;
        repeat (20) tick();
        chk("idle_rdata",   bus.rdata,      32'h0);
        chk("idle_level",   32'(level),     32'h0);
        chk("idle_pressed", 32'(pressed),   32'h0);

        // Key 0 press: level and pressed rise on edge 7.
        key_n[0] = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e == 6) chk("k0_edge6_level", 32'(level[0]), 32'h0);
        end
        chk("k0_edge7_level",   32'(level[0]),   32'h1);
        chk("k0_edge7_pressed", 32'(pressed[0]), 32'h1);
        chk("k0_rdata",         bus.rdata,       32'h11);
        key_n[0] = 1'b1;
        repeat (8) tick();
        chk("k0_release_level", 32'(level[0]), 32'h0);
        write_clear(32'h10);
        chk("k0_clr_rdata", bus.rdata, 32'h0);

        // Key 1 glitch of three synchronized cycles.
        key_n[1] = 1'b0;
        repeat (3) tick();
        key_n[1] = 1'b1;
        repeat (10) tick();
        chk("k1_glitch_level",   32'(level[1]),   32'h0);
        chk("k1_glitch_pressed", 32'(pressed[1]), 32'h0);

        // Key 2 press, clear, release.
        key_n[2] = 1'b0;
        repeat (7) tick();
        chk("k2_press_rdata", bus.rdata, 32'h44);
        write_clear(32'h40);
        chk("k2_clr_rdata", bus.rdata, 32'h04);
        key_n[2] = 1'b1;
        repeat (6) tick();
        chk("k2_rel_edge6_level", 32'(level[2]), 32'h1);
        tick();
        chk("k2_rel_edge7_level", 32'(level[2]),   32'h0);
        chk("k2_rel_pressed",     32'(pressed[2]), 32'h0);

        // Key 3: clear write lands on the same edge as entry to DOWN.
        key_n[3] = 1'b0;
        repeat (6) tick();
        write_clear(32'h80);
        chk("k3_set_wins_pressed", 32'(pressed[3]), 32'h1);
        chk("k3_set_wins_level",   32'(level[3]),   32'h1);
        tick();
        chk("k3_pressed_holds", 32'(pressed[3]), 32'h1);
        key_n[3] = 1'b1;
        repeat (8) tick();
        write_clear(32'h80);
        chk("k3_cleared_rdata", bus.rdata, 32'h0);

        // Reset during key 0 debounce, with key 1 already down.
        key_n[1] = 1'b0;
        repeat (8) tick();
        chk("k1_down_level", 32'(level[1]), 32'h1);
        key_n[0] = 1'b0;
        repeat (4) tick();
        async_reset_pulse();
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e == 6) chk("k0_post_rst_edge6", 32'(level[0]), 32'h0);
        end
        chk("k0_post_rst_level",   32'(level[0]),   32'h1);
        chk("k0_post_rst_pressed", 32'(pressed[0]), 32'h1);
        key_n = 4'hF;
        repeat (8) tick();

        // Randomized phase against the model.
        repeat (500) begin
            for (int k = 0; k < 4; k++)
                if ($urandom_range(0, 9) == 0) key_n[k] = ~key_n[k];
            bus.sel   = ($urandom_range(0, 3) != 0);
            bus.we    = ($urandom_range(0, 7) == 0);
            bus.wdata = $urandom;
            if ($urandom_range(0, 149) == 0) async_reset_pulse();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/io_key_capture.md
IO_KEY_CAPTURE -- requirements
Module: io_key_capture

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, number of consecutive clk cycles a synchronized key sample must differ from the debounced level before the level flips (legal range 1..65535).
REQ-002 Parameter NKEYS, default 4, number of push-button inputs.
REQ-003 clk  input  1  system clock (same clock as CPU and I/O registers); the block SHALL use one clock only.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 key_n  input  NKEYS  raw push-buttons, active-low, asynchronous to clk.
REQ-006 sel  input  1  CPU access targets this block (decoded I/O key address).
REQ-007 we  input  1  CPU write strobe, qualified by sel.
REQ-008 wdata  input  32  CPU write data.
REQ-009 rdata  output  32  CPU read data {24'b0, pressed[3:0], level[3:0]} when sel=1, else 32'b0.
REQ-010 level  output  NKEYS  debounced key state, 1 = held down.
REQ-011 pressed  output  NKEYS  sticky press-event flags.

Function
REQ-012 Each key_n bit SHALL pass through a 2-flop synchronizer and be inverted, giving sync[i] (1 = down).
REQ-013 Each key SHALL have an FSM with states UP, DEB_DN, DOWN, DEB_UP and a counter of width $clog2(DEBOUNCE_CYCLES+1).
REQ-014 UP: sync=1 -> DEB_DN, counter=1; else stay, counter=0.
REQ-015 DEB_DN: sync=0 -> UP, counter=0; sync=1 and counter=DEBOUNCE_CYCLES -> DOWN, counter=0; else counter+1.
REQ-016 DOWN and DEB_UP SHALL mirror REQ-014/015 with sync polarity inverted, DEB_UP resolving to UP.
REQ-017 level[i] SHALL be 1 exactly in states DOWN and DEB_UP, registered.
REQ-018 Latency: a clean raw press held stable SHALL raise level[i] on the (2+DEBOUNCE_CYCLES+1)th rising clk edge after key_n falls before that edge's setup window; release symmetric.
REQ-019 Any glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL NOT change level and SHALL restart the count.
REQ-020 pressed[i] SHALL set on the edge where the FSM enters DOWN; it SHALL NOT set on release.
REQ-021 A write with sel=1, we=1 SHALL clear pressed[i] where wdata[4+i]=1 (write-1-to-clear); other wdata bits ignored; level not writable.
REQ-022 Simultaneous set and clear of the same pressed bit in one cycle: set SHALL win.
REQ-023 rdata SHALL be combinational from registered level/pressed; reads SHALL have no side effects.
REQ-024 Keys SHALL be fully independent; simultaneous events on several keys handled in the same cycle.
REQ-025 Counter SHALL never exceed DEBOUNCE_CYCLES (no wrap).

Reset
REQ-026 reset=1 SHALL asynchronously force synchronizer flops to 0 (key up), all FSMs to UP, counters to 0, level=0, pressed=0.
REQ-027 A key held down through reset deassertion SHALL be treated as a new press: level and pressed rise after the REQ-018 latency.
REQ-028 Reset asserted mid-debounce SHALL discard the partial count.

Structure
REQ-029 Package io_pkg SHALL hold the key FSM state enum and the I/O address bit constants (LEDS bit 2, HEX bit 3, KEY bit 4, SW bit 5, I/O base bit 8).
REQ-030 Sub-module key_debounce (synchronizer + FSM + counter for one key) SHALL be instantiated NKEYS times; pressed logic and bus interface stay in io_key_capture.

Verification
REQ-031 Reset, key_n=4'hF idle 20 cycles -> level=0, pressed=0, rdata=0 with sel=1.
REQ-032 key_n[0]=0 held -> level[0]=1 and pressed[0]=1 on edge 7 (DEBOUNCE_CYCLES=4); read with sel=1 -> rdata=32'h11.
REQ-033 key_n[1] low for 3 synchronized cycles then high -> level[1] and pressed[1] stay 0.
REQ-034 After press of key 2 (rdata=32'h44), write wdata=32'h40 -> rdata=32'h04; release -> level[2]=0 after 7 edges, pressed[2] stays 0.
REQ-035 Clear write for key 3 in the same cycle its FSM enters DOWN -> pressed[3]=1.
REQ-036 Assert reset during DEB_DN of key 0 with key still down -> level=0 immediately; after deassert, level[0]=1 after 7 edges.
